execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 Parameter MD_ITERS, default 32, iterations per multiply/divide; fixed equal to XLEN.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 valid  in  1  instruction present on the inputs this cycle.
REQ-006 aluop  in  4  operation select (codes defined in mips_pkg).
REQ-007 opa, opb  in  32 each  ALU operands; opb[4:0] is the shift amount.
REQ-008 storedata  in  32  rt value for stores, passed through.
REQ-009 wbi  in  2  writeback control, passed through.
REQ-010 mi  in  1  memory write enable, passed through.
REQ-011 regaddr  in  5  destination register, passed through.
REQ-012 stall  out  1  combinational; upstream holds all inputs while high.
REQ-013 wbo  out  2  registered writeback control to the memory stage.
REQ-014 mo  out  1  registered memory write enable to the memory stage.
REQ-015 result  out  32  registered ALU result; becomes the memory stage dataaddr.
REQ-016 storeo  out  32  registered store data; becomes the memory stage data.
REQ-017 regaddrout  out  5  registered destination register.

Function
REQ-018 Single-cycle ops: ADD, SUB (mod 2^32, no overflow trap), AND, OR, XOR, NOR, SLT (signed), SLTU, SLL, SRL, SRA, LUI (opb<<16); result at the next posedge.
REQ-019 Iterative ops: MUL (low 32 bits of unsigned product), DIVU (quotient), REMU (remainder).
REQ-019a MUL uses shift-add; DIVU and REMU use restoring division; one iteration per cycle.
REQ-020 FSM states: IDLE and BUSY.
REQ-020a IDLE->BUSY on valid with an iterative op: operands load and counter cnt clears to 0.
REQ-020b In BUSY each edge performs one iteration and increments cnt.
REQ-020c BUSY->IDLE on the edge where cnt==31; that edge also loads the output registers.
REQ-021 stall = valid & iterative op & !(state==BUSY & cnt==31).
REQ-021a For an iterative op, stall is high for 32 cycles and the result appears 33 edges after issue.
REQ-022 Bubble rule: on every edge where a valid single-cycle op or a completing iterative op is not loaded, the output registers load wbo=0, mo=0, result=0, storeo=0, regaddrout=0.
REQ-022a The bubble rule covers: valid low, and iterative op in progress.
REQ-023 Divide by zero: DIVU result = 32'hFFFFFFFF; REMU result = opa; latency unchanged.
REQ-024 Pass-through fields (wbi, mi, regaddr, storedata) are sampled on the same edge as result.
REQ-024a For iterative ops, pass-through fields are sampled on the completing edge.
REQ-025 A single-cycle op following an iterative op is accepted on the edge after completion, with no extra bubble.
REQ-026 Undefined aluop codes produce result=0; control fields pass through unchanged.

Reset
REQ-027 On rstn low, asynchronously: state=IDLE, cnt=0, all output registers 0.
REQ-027a During reset, stall follows its combinational equation; with state IDLE and cnt 0, stall = valid & iterative op.
REQ-028 Reset during BUSY aborts the operation; no partial result is ever emitted.
REQ-028a After reset deassertion, a still-asserted iterative op restarts from cnt=0.

Structure
REQ-029 Package mips_pkg holds: aluop code constants, the FSM state enum, and XLEN.
REQ-030 One sub-module, muldiv_iter, holds the iterative multiply/divide: operand and accumulator registers, cnt, the done pulse, and the div-by-zero handling.
REQ-030a execute holds the combinational ALU, the FSM, the stall equation and the output registers.

Verification
REQ-031 ADD opa=7, opb=5, wbi=2'b10, regaddr=3 -> next edge: result=12, wbo=2'b10, regaddrout=3, stall never high.
REQ-032 SLT opa=32'hFFFFFFFF, opb=1 -> result=1; SLTU with the same operands -> result=0.
REQ-032a SRA opa=32'h80000000, opb=4 -> result=32'hF8000000.
REQ-033 MUL opa=12345, opb=678, held under stall -> stall high 32 cycles.
REQ-033a Same test: 32 bubbles (wbo=0, mo=0), then result=8369910 on edge 33.
REQ-034 DIVU opa=100, opb=0 -> result=32'hFFFFFFFF after 33 edges; REMU with the same operands -> 100.
REQ-034a DIVU opa=100, opb=7 -> 14; REMU with the same operands -> 2.
REQ-035 Store mi=1, opa=32'h100, opb=4, storedata=32'hDEADBEEF -> result=32'h104, mo=1, storeo=32'hDEADBEEF.
REQ-036 Reset asserted at BUSY cnt=10 -> outputs 0 immediately.
REQ-036a After release with the same DIVU held, the first valid result appears 33 edges later.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared ALU opcodes, execute-stage FSM states and datapath width.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/execute_if.sv
// ============================================================================
// Module : execute_if
// Brief  : Decode-to-execute request bus and execute-to-memory result bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface execute_if;
  import mips_pkg::*;

  logic            valid;
  logic [3:0]      aluop;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] storedata;
  logic [1:0]      wbi;
  logic            mi;
  logic [4:0]      regaddr;
  logic            stall;

  logic [1:0]      wbo;
  logic            mo;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] storeo;
  logic [4:0]      regaddrout;

  modport slave (
    input  valid, aluop, opa, opb, storedata, wbi, mi, regaddr,
    output stall, wbo, mo, result, storeo, regaddrout
  );

  modport master (
    output valid, aluop, opa, opb, storedata, wbi, mi, regaddr,
    input  stall, wbo, mo, result, storeo, regaddrout
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module : muldiv_iter
// Brief  : One-bit-per-cycle shift-add multiplier and restoring divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_iter
  import mips_pkg::*;
#(
  parameter int MD_ITERS = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            step,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            last,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int            CW     = $clog2(MD_ITERS);
  localparam logic [CW-1:0] C_LAST = CW'(MD_ITERS - 1);

  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic            r_dz;
  logic [XLEN-1:0] r_mcand, r_mplier, r_acc;
  logic [XLEN-1:0] r_quo, r_rem, r_div, r_dvd;

  logic [XLEN-1:0] w_acc_nx, w_quo_nx, w_rem_nx;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_ge;

  assign w_acc_nx = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_div};
  // Sign bit of the widened difference tells whether the divisor fits.
  assign w_ge     = ~w_diff[XLEN];
  assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

  assign last = (r_cnt == C_LAST);
  assign done = step & last;

  // The result reflects the final iteration so it can be captured on the same edge.
  always_comb begin
    res = '0;
    case (r_op)
      ALU_MUL:  res = w_acc_nx;
      ALU_DIVU: res = r_dz ? '1 : w_quo_nx;
      ALU_REMU: res = r_dz ? r_dvd : w_rem_nx;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_dz     <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_dvd    <= '0;
    end else if (start) begin
      r_cnt    <= '0;
      r_op     <= op;
      r_dz     <= (opb == '0);
      r_mcand  <= opa;
      r_mplier <= opb;
      r_acc    <= '0;
      r_quo    <= opa;
      r_rem    <= '0;
      r_div    <= opb;
      r_dvd    <= opa;
    end else if (step) begin
      r_cnt    <= r_cnt + 1'b1;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_nx;
      r_quo    <= w_quo_nx;
      r_rem    <= w_rem_nx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute.sv
// ============================================================================
// Module : execute
// Brief  : MIPS execute stage: single-cycle ALU plus iterative mul/div.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module execute #(
  parameter int XLEN     = 32,
  parameter int MD_ITERS = 32
) (
  input  logic     clk,
  input  logic     rstn,
  execute_if.slave bus
);
  import mips_pkg::*;

  state_t          r_state;
  logic [1:0]      r_wbo;
  logic            r_mo;
  logic [XLEN-1:0] r_result, r_storeo;
  logic [4:0]      r_regaddrout;

  logic            w_iter, w_load_alu, w_md_start, w_md_step, w_md_last, w_md_done;
  logic [XLEN-1:0] w_alu, w_md_res;

  assign w_iter     = is_iter_op(bus.aluop);
  assign w_load_alu = (r_state == ST_IDLE) & bus.valid & ~w_iter;
  assign w_md_start = (r_state == ST_IDLE) & bus.valid & w_iter;
  assign w_md_step  = (r_state == ST_BUSY);

  assign bus.stall  = bus.valid & w_iter & ~(w_md_step & w_md_last);

  muldiv_iter #(
    .MD_ITERS (MD_ITERS)
  ) u_muldiv (
    .clk   (clk),
    .rstn  (rstn),
    .start (w_md_start),
    .step  (w_md_step),
    .op    (bus.aluop),
    .opa   (bus.opa),
    .opb   (bus.opb),
    .last  (w_md_last),
    .done  (w_md_done),
    .res   (w_md_res)
  );

  always_comb begin
    w_alu = '0;
    case (bus.aluop)
      ALU_ADD:  w_alu = bus.opa + bus.opb;
      ALU_SUB:  w_alu = bus.opa - bus.opb;
      ALU_AND:  w_alu = bus.opa & bus.opb;
      ALU_OR:   w_alu = bus.opa | bus.opb;
      ALU_XOR:  w_alu = bus.opa ^ bus.opb;
      ALU_NOR:  w_alu = ~(bus.opa | bus.opb);
      ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(bus.opa) < $signed(bus.opb))};
      ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (bus.opa < bus.opb)};
      ALU_SLL:  w_alu = bus.opa << bus.opb[4:0];
      ALU_SRL:  w_alu = bus.opa >> bus.opb[4:0];
      ALU_SRA:  w_alu = $signed(bus.opa) >>> bus.opb[4:0];
      ALU_LUI:  w_alu = bus.opb << 16;
      default:  w_alu = '0;
    endcase
  end

  // Any edge that neither accepts a single-cycle op nor completes mul/div emits a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_wbo        <= '0;
      r_mo         <= 1'b0;
      r_result     <= '0;
      r_storeo     <= '0;
      r_regaddrout <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_md_start) r_state <= ST_BUSY;
        ST_BUSY: if (w_md_done)  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_load_alu || w_md_done) begin
        r_wbo        <= bus.wbi;
        r_mo         <= bus.mi;
        r_result     <= w_md_done ? w_md_res : w_alu;
        r_storeo     <= bus.storedata;
        r_regaddrout <= bus.regaddr;
      end else begin
        r_wbo        <= '0;
        r_mo         <= 1'b0;
        r_result     <= '0;
        r_storeo     <= '0;
        r_regaddrout <= '0;
      end
    end
  end

  assign bus.wbo        = r_wbo;
  assign bus.mo         = r_mo;
  assign bus.result     = r_result;
  assign bus.storeo     = r_storeo;
  assign bus.regaddrout = r_regaddrout;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// ============================================================================
// Module : tb_execute
// Brief  : Scoreboard bench for the execute stage with a behavioural ALU model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_execute;
  import mips_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  execute_if bus ();

  execute #(
    .XLEN     (32),
    .MD_ITERS (32)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [1:0]  wbo;
    logic        mo;
    logic [31:0] result;
    logic [31:0] storeo;
    logic [4:0]  ra;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_LUI:  return {b[15:0], 16'h0000};
      ALU_MUL:  return a * b;
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare the scoreboard head when due, otherwise expect a bubble.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("result", 64'(bus.result),     64'(e.result));
      chk("wbo",    64'(bus.wbo),        64'(e.wbo));
      chk("mo",     64'(bus.mo),         64'(e.mo));
      chk("storeo", 64'(bus.storeo),     64'(e.storeo));
      chk("raddr",  64'(bus.regaddrout), 64'(e.ra));
    end else begin
      chk("bubble_res", 64'(bus.result), 64'd0);
      chk("bubble_ctl", {24'd0, bus.storeo, bus.wbo, bus.mo, bus.regaddrout}, 64'd0);
    end
  end

  // Called at posedge+1; holds the instruction while stalled and returns at posedge+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic [1:0] wb, input logic m, input logic [4:0] ra);
    exp_t e;
    logic it;
    int   n;
    bus.valid = 1'b1; bus.aluop = op; bus.opa = a; bus.opb = b;
    bus.storedata = sd; bus.wbi = wb; bus.mi = m; bus.regaddr = ra;
    it = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    n  = it ? 33 : 1;
    e.due = cyc + n; e.wbo = wb; e.mo = m; e.result = ref_alu(op, a, b);
    e.storeo = sd; e.ra = ra;
    sb.push_back(e);
    for (int k = 0; k < n; k++) begin
      #1;
      chk("stall", 64'(bus.stall), 64'(it && (k < 32)));
      @(posedge clk);
      #1;
    end
    bus.valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.valid = 1'b0;
    bus.aluop = 4'($urandom_range(0, 15));
    bus.opa = $urandom; bus.opb = $urandom;
    #1;
    chk("stall_idle", 64'(bus.stall), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : drv
    logic [3:0]  op;
    logic [31:0] a, b;
    int unsigned r;

    bus.valid = 1'b0; bus.aluop = '0; bus.opa = '0; bus.opb = '0;
    bus.storedata = '0; bus.wbi = '0; bus.mi = 1'b0; bus.regaddr = '0;
    #1;
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_ctl", {24'd0, bus.storeo, bus.wbo, bus.mo, bus.regaddrout}, 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    run_op(ALU_ADD,  32'd7,         32'd5, 32'd0, 2'b10, 1'b0, 5'd3);
    run_op(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01, 1'b0, 5'd4);
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b01, 1'b0, 5'd5);
    run_op(ALU_SRA,  32'h8000_0000, 32'd4, 32'd0, 2'b01, 1'b0, 5'd6);
    run_op(ALU_MUL,  32'd12345,     32'd678, 32'h1111, 2'b11, 1'b0, 5'd7);
    run_op(ALU_ADD,  32'd1,         32'd2, 32'd0, 2'b01, 1'b0, 5'd8);
    run_op(ALU_DIVU, 32'd100,       32'd0, 32'd0, 2'b01, 1'b0, 5'd9);
    run_op(ALU_REMU, 32'd100,       32'd0, 32'd0, 2'b01, 1'b0, 5'd10);
    run_op(ALU_DIVU, 32'd100,       32'd7, 32'd0, 2'b01, 1'b0, 5'd11);
    run_op(ALU_REMU, 32'd100,       32'd7, 32'd0, 2'b01, 1'b0, 5'd12);
    run_op(ALU_ADD,  32'h100,       32'd4, 32'hDEAD_BEEF, 2'b00, 1'b1, 5'd0);
    run_op(4'd15,    32'h1234,      32'h5678, 32'hCAFE, 2'b11, 1'b1, 5'd31);
    run_op(ALU_LUI,  32'd0,         32'h0000_ABCD, 32'd0, 2'b01, 1'b0, 5'd13);
    idle_cycle();

    // Asynchronous reset while a result is sitting on the outputs.
    run_op(ALU_ADD, 32'd7, 32'd5, 32'd0, 2'b10, 1'b0, 5'd3);
    #5;
    rstn = 1'b0;
    #1;
    chk("rst_idle_result", 64'(bus.result), 64'd0);
    chk("rst_idle_wbo", 64'(bus.wbo), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset in the middle of a divide, then restart with the same op held.
    bus.valid = 1'b1; bus.aluop = ALU_DIVU; bus.opa = 32'd100; bus.opb = 32'd7;
    bus.storedata = 32'h55; bus.wbi = 2'b01; bus.mi = 1'b0; bus.regaddr = 5'd14;
    repeat (11) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_busy_result", 64'(bus.result), 64'd0);
    chk("rst_busy_ctl", {24'd0, bus.storeo, bus.wbo, bus.mo, bus.regaddrout}, 64'd0);
    chk("rst_busy_stall", 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1;
    chk("rst_hold_result", 64'(bus.result), 64'd0);
    rstn = 1'b1;
    run_op(ALU_DIVU, 32'd100, 32'd7, 32'h55, 2'b01, 1'b0, 5'd14);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)       op = 4'(12 + $urandom_range(0, 2));
      else if (r == 3) op = 4'd15;
      else             op = 4'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(op, a, b, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    repeat (3) idle_cycle();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
